// File: rtl/exponential_pkg_scrap.sv
// Shared types and constants for the bfloat16 exponential datapath scrap area.
package exponential_pkg_scrap;

  localparam int unsigned REQ_W         = 53;
  localparam int unsigned RES_W         = 24;
  localparam int unsigned TAY_AU_LAT    = 2;
  localparam int unsigned TAY_ARB_DEPTH = 4;
  localparam int unsigned TAY_ARB_ACC   = 0;
  localparam int unsigned TAY_ARB_RR    = 1;

  // One operand as presented to the Taylor add/sub unit.
  typedef struct packed {
    logic       s;
    logic [7:0] extF;
    logic [8:0] extE;
    logic       isInf;
    logic       isSNAN;
    logic       isQNAN;
  } tay_op_t;

  // Full request: two operands plus the pre-computed alignment info.
  typedef struct packed {
    tay_op_t    op1;
    tay_op_t    op2;
    logic       isOpSub;
    logic       op1_GT_op2;
    logic [8:0] e_diff;
  } tay_addsub_req_t;

  // Result word returned by the add/sub unit.
  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [11:0] f;
    logic        isOverflow;
    logic        isUnderflow;
    logic        isToRound;
  } tay_addsub_res_t;

endpackage

// File: rtl/tay_arb_res_fifo.sv
// First-word-fall-through result FIFO with an occupancy count for credit tracking.
module tay_arb_res_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pushValid,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       popReady,
  output logic                       popValid,
  output logic [WIDTH-1:0]           popData,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  // A push into a full FIFO is dropped; the parent flags it.
  assign doPush   = pushValid && (count != CNT_W'(DEPTH));
  assign doPop    = popReady && (count != '0);
  assign popValid = (count != '0);
  assign popData  = popValid ? mem[rdPtr] : '0;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/tay_addsub_arbiter.sv
// Round-robin, credit-gated sharing of the Taylor add/sub unit between the
// term accumulator (requester 0) and range reduction (requester 1).
module tay_addsub_arbiter
  import exponential_pkg_scrap::*;
#(
  parameter int unsigned DEPTH = TAY_ARB_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [REQ_W-1:0] req0_pld_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [REQ_W-1:0] req1_pld_i,
  output logic             res0_valid_o,
  input  logic             res0_ready_i,
  output logic [RES_W-1:0] res0_pld_o,
  output logic             res1_valid_o,
  input  logic             res1_ready_i,
  output logic [RES_W-1:0] res1_pld_o,
  output logic             au_doAddSub_o,
  output logic [REQ_W-1:0] au_pld_o,
  input  logic             au_valid_i,
  input  logic [RES_W-1:0] au_res_i,
  output logic             err_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned TAG_N = TAY_AU_LAT + 1;

  logic [CNT_W-1:0] cnt0, cnt1, infl0, infl1;
  logic             elig0, elig1, grant0, grant1;
  logic             lastGnt;
  logic [TAG_N-1:0] tagV, tagOwn;
  logic             wb0, wb1, ovf0, ovf1;
  tay_addsub_req_t  issuePld;

  // Credit check and round-robin pick; lastGnt=1 means requester 0 wins a tie.
  always_comb begin
    elig0    = req0_valid_i && ((SUM_W'(cnt0) + SUM_W'(infl0)) < SUM_W'(DEPTH));
    elig1    = req1_valid_i && ((SUM_W'(cnt1) + SUM_W'(infl1)) < SUM_W'(DEPTH));
    grant0   = elig0 && (!elig1 || lastGnt);
    grant1   = elig1 && (!elig0 || !lastGnt);
    issuePld = grant1 ? tay_addsub_req_t'(req1_pld_i) : tay_addsub_req_t'(req0_pld_i);
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;

  // Result ownership is taken from the tag tail, which lines up with au_valid_i.
  assign wb0  = au_valid_i && (tagOwn[TAG_N-1] == 1'(TAY_ARB_ACC));
  assign wb1  = au_valid_i && (tagOwn[TAG_N-1] == 1'(TAY_ARB_RR));
  assign ovf0 = wb0 && (cnt0 == CNT_W'(DEPTH));
  assign ovf1 = wb1 && (cnt1 == CNT_W'(DEPTH));

  // Round-robin history, moved only when something is granted.
  always_ff @(posedge clk) begin
    if (rst)         lastGnt <= 1'b1;
    else if (grant0) lastGnt <= 1'b0;
    else if (grant1) lastGnt <= 1'b1;
  end

  // Issue register: strobe for one cycle, payload holds between issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      au_doAddSub_o <= 1'b0;
      au_pld_o      <= '0;
    end else begin
      au_doAddSub_o <= grant0 || grant1;
      if (grant0 || grant1) au_pld_o <= REQ_W'(issuePld);
    end
  end

  // Tag pipeline shadowing the unit latency plus the issue register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tagV   <= '0;
      tagOwn <= '0;
    end else begin
      tagV   <= {tagV[TAG_N-2:0], grant0 || grant1};
      tagOwn <= {tagOwn[TAG_N-2:0], grant1};
    end
  end

  // In-flight counters: +1 on grant, -1 on writeback, both cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      infl0 <= '0;
      infl1 <= '0;
    end else begin
      case ({grant0, wb0})
        2'b10:   infl0 <= infl0 + CNT_W'(1);
        2'b01:   infl0 <= infl0 - CNT_W'(1);
        default: infl0 <= infl0;
      endcase
      case ({grant1, wb1})
        2'b10:   infl1 <= infl1 + CNT_W'(1);
        2'b01:   infl1 <= infl1 - CNT_W'(1);
        default: infl1 <= infl1;
      endcase
    end
  end

  // Sticky protocol error: tag/valid disagreement or a push into a full FIFO.
  always_ff @(posedge clk) begin
    if (rst)                                            err_o <= 1'b0;
    else if ((tagV[TAG_N-1] != au_valid_i) || ovf0 || ovf1) err_o <= 1'b1;
  end

  tay_arb_res_fifo #(.DEPTH(DEPTH), .WIDTH(RES_W)) uFifo0 (
    .clk       (clk),
    .rst       (rst),
    .pushValid (wb0),
    .pushData  (au_res_i),
    .popReady  (res0_ready_i),
    .popValid  (res0_valid_o),
    .popData   (res0_pld_o),
    .count     (cnt0)
  );

  tay_arb_res_fifo #(.DEPTH(DEPTH), .WIDTH(RES_W)) uFifo1 (
    .clk       (clk),
    .rst       (rst),
    .pushValid (wb1),
    .pushData  (au_res_i),
    .popReady  (res1_ready_i),
    .popValid  (res1_valid_o),
    .popData   (res1_pld_o),
    .count     (cnt1)
  );

endmodule
